// File: rtl/paddle_ctrl.sv
// Purpose : per-player paddle position controller; left/right buttons -> clamped position with hold-to-repeat.
// Latency : one cycle; a step decided at an edge is visible on pos/moved right after that edge.
// Backpr. : none; buttons are sampled every edge, blocked steps at the field edges are simply dropped.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   en                game-running enable; low forces every channel back to START/IDLE
//   left, right       synchronised button levels, bit i = player i
//   pos               left-edge paddle position, player i in [i*POS_W +: POS_W]
//   moved             one-cycle pulse per player on each edge where that player's pos changed
module paddle_ctrl #(
    parameter int PLAYERS = 2,
    parameter int FIELD_W = 8,
    parameter int POS_W   = 3,
    parameter int SIZE    = 2,
    parameter int START   = 3,
    parameter int HOLD    = 4,
    parameter int REPEAT  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [PLAYERS-1:0]       left,
    input  logic [PLAYERS-1:0]       right,
    output logic [PLAYERS*POS_W-1:0] pos,
    output logic [PLAYERS-1:0]       moved
);

    localparam int CNT_MAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [POS_W-1:0] MAX_POS   = POS_W'(FIELD_W - SIZE);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_RPT
    } state_t;

    for (genvar g = 0; g < PLAYERS; g++) begin : g_ch
        state_t           state_q;
        logic             dir_q;      // latched direction: 1 = right, 0 = left
        logic [CNT_W-1:0] cnt_q;
        logic [POS_W-1:0] pos_q;
        logic             moved_q;

        logic             go_l;
        logic             go_r;
        logic             same_dir;
        logic             step_ok;
        logic [POS_W-1:0] pos_d;

        // Both buttons pressed decodes to no direction.
        assign go_l     = left[g] & ~right[g];
        assign go_r     = right[g] & ~left[g];
        assign same_dir = dir_q ? go_r : go_l;

        // Step candidate in the currently decoded direction. Outside IDLE a
        // step is only taken while same_dir holds, so go_r equals dir_q there.
        assign step_ok  = go_r ? (pos_q < MAX_POS) : (go_l && (pos_q != '0));
        assign pos_d    = go_r ? (pos_q + 1'b1) : (pos_q - 1'b1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                dir_q   <= 1'b0;
                cnt_q   <= '0;
                pos_q   <= START_POS;
                moved_q <= 1'b0;
            end else if (!en) begin
                state_q <= ST_IDLE;
                dir_q   <= 1'b0;
                cnt_q   <= '0;
                pos_q   <= START_POS;
                moved_q <= 1'b0;
            end else begin
                moved_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (go_l || go_r) begin
                            // The press is consumed even if the step is blocked.
                            if (step_ok) begin
                                pos_q   <= pos_d;
                                moved_q <= 1'b1;
                            end
                            dir_q   <= go_r;
                            cnt_q   <= '0;
                            state_q <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!same_dir) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else if (HOLD == 0) begin
                            // Auto-repeat disabled: park here until release.
                            state_q <= ST_HELD;
                        end else if (cnt_q == HOLD_LAST) begin
                            if (step_ok) begin
                                pos_q   <= pos_d;
                                moved_q <= 1'b1;
                            end
                            cnt_q   <= '0;
                            state_q <= ST_RPT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!same_dir) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end else if (cnt_q == RPT_LAST) begin
                            if (step_ok) begin
                                pos_q   <= pos_d;
                                moved_q <= 1'b1;
                            end
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pos[g*POS_W +: POS_W] = pos_q;
        assign moved[g]              = moved_q;
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Purpose : bench for paddle_ctrl; a default instance and a no-auto-repeat instance share the same buttons.
// Latency : expectations are queued when a cycle's inputs are driven and popped 1 time unit after the edge.
// Backpr. : none.
module tb_paddle_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] left;
    logic [1:0] right;
    logic [5:0] pos_a;
    logic [1:0] moved_a;
    logic [5:0] pos_b;
    logic [1:0] moved_b;

    int checks = 0;
    int errors = 0;

    paddle_ctrl u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .left  (left),
        .right (right),
        .pos   (pos_a),
        .moved (moved_a)
    );

    paddle_ctrl #(.HOLD(0)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .left  (left),
        .right (right),
        .pos   (pos_b),
        .moved (moved_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference model written from the timing rule: counting edges k since
    // the press edge, steps fall at k = 0, HOLD, HOLD+REPEAT, ...
    localparam int REP    = 2;
    localparam int MAXP   = 6;
    localparam int STARTP = 3;
    int hold_of [2] = '{4, 0};
    int m_act [2][2];   // 0 idle, 1 left, 2 right
    int m_k   [2][2];
    int m_pos [2][2];
    int m_mv  [2][2];

    typedef struct {
        logic [5:0] pos_a;
        logic [1:0] mv_a;
        logic [5:0] pos_b;
        logic [1:0] mv_b;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < 2; p++) begin
                m_act[n][p] = 0;
                m_k[n][p]   = 0;
                m_pos[n][p] = STARTP;
                m_mv[n][p]  = 0;
            end
    endtask

    task automatic model_step(input logic e, input logic [1:0] l, input logic [1:0] r);
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < 2; p++) begin
                int dir;
                bit stepnow;
                m_mv[n][p] = 0;
                if (!e) begin
                    m_act[n][p] = 0;
                    m_k[n][p]   = 0;
                    m_pos[n][p] = STARTP;
                end else begin
                    dir     = (l[p] && !r[p]) ? 1 : ((r[p] && !l[p]) ? 2 : 0);
                    stepnow = 0;
                    if (m_act[n][p] == 0) begin
                        if (dir != 0) begin
                            m_act[n][p] = dir;
                            m_k[n][p]   = 0;
                            stepnow     = 1;
                        end
                    end else if (dir == m_act[n][p]) begin
                        m_k[n][p]++;
                        if (hold_of[n] > 0 && m_k[n][p] >= hold_of[n] &&
                            ((m_k[n][p] - hold_of[n]) % REP) == 0)
                            stepnow = 1;
                    end else begin
                        m_act[n][p] = 0;
                        m_k[n][p]   = 0;
                    end
                    if (stepnow) begin
                        if (dir == 1 && m_pos[n][p] > 0) begin
                            m_pos[n][p]--;
                            m_mv[n][p] = 1;
                        end else if (dir == 2 && m_pos[n][p] < MAXP) begin
                            m_pos[n][p]++;
                            m_mv[n][p] = 1;
                        end
                    end
                end
            end
    endtask

    // Drive one cycle, queue the model's expectation, then compare after the edge.
    task automatic cycle(input logic e, input logic [1:0] l, input logic [1:0] r);
        exp_t x;
        exp_t got_x;
        en    = e;
        left  = l;
        right = r;
        model_step(e, l, r);
        x.pos_a = {3'(m_pos[0][1]), 3'(m_pos[0][0])};
        x.mv_a  = {1'(m_mv[0][1]), 1'(m_mv[0][0])};
        x.pos_b = {3'(m_pos[1][1]), 3'(m_pos[1][0])};
        x.mv_b  = {1'(m_mv[1][1]), 1'(m_mv[1][0])};
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            got_x = sb.pop_front();
            chk("sb_pos_a",   pos_a,   got_x.pos_a);
            chk("sb_moved_a", moved_a, got_x.mv_a);
            chk("sb_pos_b",   pos_b,   got_x.pos_b);
            chk("sb_moved_b", moved_b, got_x.mv_b);
        end
    endtask

    int exp_hold_pos [12] = '{4, 4, 4, 4, 5, 5, 6, 6, 6, 6, 6, 6};
    int exp_hold_mv  [12] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        left  = 2'b00;
        right = 2'b00;
        model_reset();

        // Asynchronous reset, checked without any clock edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_pos_a",   pos_a,   27);
        chk("rst_moved_a", moved_a, 0);
        chk("rst_pos_b",   pos_b,   27);
        #1 rst = 1'b0;
        #1;
        chk("rst_rel_pos_a", pos_a, 27);
        @(posedge clk);
        #1;

        // Single presses.
        cycle(1'b1, 2'b00, 2'b01);
        chk("single_pos0",   pos_a[2:0], 4);
        chk("single_moved",  moved_a,    1);
        chk("single_pos1",   pos_a[5:3], 3);
        cycle(1'b1, 2'b00, 2'b00);
        chk("single_moved_clr", moved_a, 0);
        cycle(1'b1, 2'b00, 2'b01);
        chk("repress_pos0", pos_a[2:0], 5);
        cycle(1'b1, 2'b00, 2'b00);

        // Hold right from 3 for 12 edges: steps at 0, 4, 6, blocked at 8, 10.
        cycle(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 2'b00, 2'b01);
            chk($sformatf("hold_pos%0d", i),   pos_a[2:0], exp_hold_pos[i]);
            chk($sformatf("hold_moved%0d", i), moved_a[0], exp_hold_mv[i]);
        end
        cycle(1'b1, 2'b00, 2'b00);

        // Both buttons on player 1, then both players left together.
        cycle(1'b0, 2'b00, 2'b00);
        cycle(1'b1, 2'b10, 2'b10);
        chk("both_btn_pos1", pos_a[5:3], 3);
        chk("both_btn_mv",   moved_a,    0);
        cycle(1'b1, 2'b00, 2'b00);
        cycle(1'b1, 2'b11, 2'b00);
        chk("dual_left_pos", pos_a,   6'b010_010);
        chk("dual_left_mv",  moved_a, 3);
        cycle(1'b1, 2'b00, 2'b00);

        // Reversal without release: needs an idle cycle first.
        cycle(1'b1, 2'b00, 2'b01);
        cycle(1'b1, 2'b01, 2'b00);
        chk("reverse_nostep", moved_a[0], 0);
        cycle(1'b1, 2'b01, 2'b00);
        chk("reverse_step", pos_a[2:0], 2);
        cycle(1'b1, 2'b00, 2'b00);

        // Drop en mid-repeat at pos 5, then re-enable with the button held.
        cycle(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'b00, 2'b01);
        chk("rpt_pos", pos_a[2:0], 5);
        cycle(1'b0, 2'b00, 2'b01);
        chk("en_drop_pos", pos_a[2:0], 3);
        chk("en_drop_mv",  moved_a,    0);
        cycle(1'b1, 2'b00, 2'b01);
        chk("en_rise_pos", pos_a[2:0], 4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 2'b01);
        chk("en_rise_hold", pos_a[2:0], 4);
        cycle(1'b1, 2'b00, 2'b01);
        chk("en_rise_rpt", pos_a[2:0], 5);
        cycle(1'b1, 2'b00, 2'b00);

        // No-auto-repeat instance: one step per press.
        cycle(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) cycle(1'b1, 2'b01, 2'b00);
        chk("h0_hold_pos", pos_b[2:0], 2);
        cycle(1'b1, 2'b00, 2'b00);
        cycle(1'b1, 2'b01, 2'b00);
        chk("h0_repress_pos", pos_b[2:0], 1);
        cycle(1'b1, 2'b00, 2'b00);

        // Reset mid-hold takes effect immediately.
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'b10, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_pos_a", pos_a,   27);
        chk("rst_mid_mv_a",  moved_a, 0);
        chk("rst_mid_pos_b", pos_b,   27);
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b1, 2'b10, 2'b01);
        chk("rst_mid_press", pos_a, 6'b010_100);

        // Random stretch against the model.
        for (int i = 0; i < 400; i++) begin
            logic       e;
            logic [1:0] l;
            logic [1:0] r;
            e = ($urandom_range(0, 31) != 0);
            l = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                // Bias toward long holds so repeats and bounds are exercised.
                l = left;
                r = right;
            end
            cycle(e, l, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Multi-player paddle position controller for the pong datapath. Each of `PLAYERS` independent channels turns a left/right button pair into a clamped paddle position. Each channel has edge-triggered single steps and optional hold-to-repeat. The block sits between the input synchroniser and the renderer/collision logic, and it replaces the single-player, click-only paddle state register.

## Interface
Parameters:
- `PLAYERS`, 2, number of independent paddle channels
- `FIELD_W`, 8, field width in cells
- `POS_W`, 3, position width per channel; must satisfy 2^POS_W >= FIELD_W
- `SIZE`, 2, paddle width in cells
- `START`, 3, position loaded on reset and while disabled; must be <= FIELD_W-SIZE
- `HOLD`, 4, cycles a button must stay held before auto-repeat starts; 0 disables auto-repeat (single step per press)
- `REPEAT`, 2, cycles between auto-repeat steps; must be >= 1

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge
- `rst`, in, 1, asynchronous, active-high reset
- `en`, in, 1, game-running enable
- `left`, in, PLAYERS, left button, bit i is player i; already synchronised
- `right`, in, PLAYERS, right button, bit i is player i
- `pos`, out, PLAYERS*POS_W, left-edge position of each paddle; player i is in bits [i*POS_W +: POS_W]
- `moved`, out, PLAYERS, one-cycle pulse on each edge where that player's `pos` changed

## Operation
- Legal range per channel is 0..MAX, where MAX = FIELD_W-SIZE.
- Per channel, the direction is decoded as follows: L = left & ~right, R = right & ~left. When both buttons or neither are pressed, the direction is NONE.
- A step is pos-1 when L and pos>0, or pos+1 when R and pos<MAX. Otherwise it is blocked: pos is unchanged and `moved` stays 0.
- Each channel runs its own FSM with states IDLE, HELD and RPT, plus a counter `cnt` sized for max(HOLD,REPEAT).
  - IDLE: on L or R, attempt a step, latch the direction, clear `cnt`, and go to HELD. On NONE, stay in IDLE.
  - HELD: if the direction is not the latched one (released, reversed, or both pressed), go to IDLE with no step. If HOLD=0, stay in HELD. Otherwise, if cnt==HOLD-1, attempt a step, clear `cnt` and go to RPT; else increment `cnt`.
  - RPT: if the direction is not the latched one, go to IDLE. Otherwise, if cnt==REPEAT-1, attempt a step and clear `cnt`; else increment `cnt`.
- A press is consumed even when its step is blocked at a boundary. There is no step on release.
- A direction reversal needs one cycle in IDLE before the new direction is taken.
- When `en`=0, this is evaluated synchronously every edge: all `pos` are set to START, all FSMs go to IDLE, `cnt` is cleared and `moved` is 0. This takes priority over button inputs.
- Channels never interact. Simultaneous presses on different players are all serviced in the same cycle.
- Position arithmetic is unsigned POS_W-bit. The bound checks guarantee that no wrap-around occurs.

## Timing
- `rst` asserted: immediately, `pos` = START on every channel, `moved` = 0, FSMs in IDLE, `cnt` = 0. `rst` overrides `en` and takes effect mid-hold or mid-repeat.
- All outputs are registered. A step decided at edge k is visible on `pos` after edge k, and `moved` is high for exactly the cycle following edge k.
- With a button held continuously from edge 0 (first sample), steps occur at edges 0, HOLD, HOLD+REPEAT, HOLD+2·REPEAT, and so on, until the bound is reached or the button is released.
- Releasing at edge k means IDLE after edge k. A new press sampled at edge k+1 steps at edge k+1.

## Test plan
- Assert `rst` mid-cycle, then release it → `pos` reads 3 for both players with no clock edge needed; `moved`=00.
- Player 0 `right` high for 1 cycle, `en`=1 → pos0=4 after that edge, `moved`=01 for one cycle, pos1 stays 3. Re-pressing after release → pos0=5.
- Player 0 `right` held for 12 edges from pos0=3 → steps at edges 0, 4, 6, reaching pos 4, 5, 6 (MAX=6). At edges 8 and 10 the step is blocked: pos0 stays 6 and `moved`[0] stays 0.
- Player 1 `left`+`right` both high → no step, pos1=3. Both players pressing `left` in the same cycle → pos = 2, 2 and `moved`=11.
- Drop `en` while player 0 is in RPT at pos0=5 → pos0=3 after the next edge, FSM in IDLE. Raising `en` with the button still held → one step at the next edge (pos0=4), then the HOLD delay applies again.
- Instance with HOLD=0, `left` held for 10 edges from 3 → exactly one step to 2. Release, then press again → steps to 1.
